gfx_cmd_scheduler: RTL and testbench

//  Sequences CPU graphics commands onto the line engine and the filler engine. The CPU writes

---
 rtl/gfx_cmd_if.sv | 37 +++
 rtl/gfx_cmd_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_gfx_cmd_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx_cmd_if.sv
// Bus bundle between the CPU/engine side and the graphics command scheduler:
// MMIO window, line-engine transfer ports and filler-engine request port.
interface gfx_cmd_if #(
   parameter int unsigned PT_W = 10
);
   logic            mmio_we;
   logic [2:0]      mmio_addr;
   logic [31:0]     mmio_din;
   logic [31:0]     mmio_dout;
   logic            gfx_idle;
   logic            line_ready;
   logic [31:0]     line_color;
   logic [PT_W-1:0] line_point;
   logic            line_color_valid;
   logic            line_x0_valid;
   logic            line_y0_valid;
   logic            line_x1_valid;
   logic            line_y1_valid;
   logic            line_trigger;
   logic            filler_ready;
   logic [23:0]     filler_color;
   logic            filler_valid;

   modport master (
      output mmio_we, mmio_addr, mmio_din, line_ready, filler_ready,
      input  mmio_dout, gfx_idle, line_color, line_point, line_color_valid,
             line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid,
             line_trigger, filler_color, filler_valid
   );

   modport slave (
      input  mmio_we, mmio_addr, mmio_din, line_ready, filler_ready,
      output mmio_dout, gfx_idle, line_color, line_point, line_color_valid,
             line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid,
             line_trigger, filler_color, filler_valid
   );
endinterface

// File: rtl/gfx_cmd_scheduler.sv
// Queues CPU line/fill commands and issues them one at a time to the line
// and filler engines so the two never touch the framebuffer together.
module gfx_cmd_scheduler #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PT_W       = 10
) (
   input logic      clk,
   input logic      rst,
   gfx_cmd_if.slave bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_L_COLOR, S_L_X0, S_L_Y0, S_L_X1, S_L_Y1, S_L_TRIG,
      S_F_REQ, S_DRAIN, S_WAIT_RDY
   } state_t;

   typedef struct packed {
      logic            is_fill;
      logic [31:0]     color;
      logic [PT_W-1:0] x0;
      logic [PT_W-1:0] y0;
      logic [PT_W-1:0] x1;
      logic [PT_W-1:0] y1;
   } cmd_t;

   state_t          state, state_n;
   logic [31:0]     color_r;
   logic [PT_W-1:0] x0_r, y0_r, x1_r, y1_r;
   cmd_t            mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr, count;
   logic            full, empty, is_go, push, pop, ovf_evt, overflow;
   cmd_t            head, new_cmd;
   logic            cur_fill;
   logic [PT_W-1:0] cur_x0, cur_y0, cur_x1, cur_y1;
   logic [31:0]     line_color_q;
   logic [23:0]     filler_color_q;
   logic [PT_W-1:0] line_point_q;
   logic            color_v, x0_v, y0_v, x1_v, y1_v, trig_v, fill_v;
   logic [31:0]     count_ext, status;
   logic [2:0]      occ;

   // Fullness is taken from the pre-edge count, so a same-cycle pop never frees a slot.
   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == PW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign is_go   = bus.mmio_we && (bus.mmio_addr == 3'd5 || bus.mmio_addr == 3'd6);
   assign push    = is_go && !full;
   assign ovf_evt = is_go && full;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign pop     = (state == S_IDLE) && !empty;

   always_comb begin
      new_cmd         = '0;
      new_cmd.is_fill = (bus.mmio_addr == 3'd6);
      new_cmd.color   = new_cmd.is_fill ? {8'h00, bus.mmio_din[23:0]} : color_r;
      new_cmd.x0      = x0_r;
      new_cmd.y0      = y0_r;
      new_cmd.x1      = x1_r;
      new_cmd.y1      = y1_r;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= new_cmd;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:     if (!empty) state_n = head.is_fill ? S_F_REQ : S_L_COLOR;
         S_L_COLOR:  if (bus.line_ready) state_n = S_L_X0;
         S_L_X0:     if (bus.line_ready) state_n = S_L_Y0;
         S_L_Y0:     if (bus.line_ready) state_n = S_L_X1;
         S_L_X1:     if (bus.line_ready) state_n = S_L_Y1;
         S_L_Y1:     if (bus.line_ready) state_n = S_L_TRIG;
         S_L_TRIG:   if (bus.line_ready) state_n = S_DRAIN;
         S_F_REQ:    if (bus.filler_ready) state_n = S_DRAIN;
         S_DRAIN:    state_n = S_WAIT_RDY;
         S_WAIT_RDY: if (cur_fill ? bus.filler_ready : bus.line_ready) state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end

   // Valids are decoded from the next state so they drop on the completing edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= S_IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         overflow       <= 1'b0;
         color_r        <= '0;
         x0_r           <= '0;
         y0_r           <= '0;
         x1_r           <= '0;
         y1_r           <= '0;
         cur_fill       <= 1'b0;
         cur_x0         <= '0;
         cur_y0         <= '0;
         cur_x1         <= '0;
         cur_y1         <= '0;
         line_color_q   <= '0;
         filler_color_q <= '0;
         line_point_q   <= '0;
         color_v        <= 1'b0;
         x0_v           <= 1'b0;
         y0_v           <= 1'b0;
         x1_v           <= 1'b0;
         y1_v           <= 1'b0;
         trig_v         <= 1'b0;
         fill_v         <= 1'b0;
      end else begin
         if (bus.mmio_we) begin
            case (bus.mmio_addr)
               3'd0:    color_r <= bus.mmio_din;
               3'd1:    x0_r    <= bus.mmio_din[PT_W-1:0];
               3'd2:    y0_r    <= bus.mmio_din[PT_W-1:0];
               3'd3:    x1_r    <= bus.mmio_din[PT_W-1:0];
               3'd4:    y1_r    <= bus.mmio_din[PT_W-1:0];
               default: ;
            endcase
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (ovf_evt)
            overflow <= 1'b1;
         else if (bus.mmio_we && bus.mmio_addr == 3'd7 && bus.mmio_din[3])
            overflow <= 1'b0;

         state <= state_n;
         if (pop) begin
            cur_fill <= head.is_fill;
            cur_x0   <= head.x0;
            cur_y0   <= head.y0;
            cur_x1   <= head.x1;
            cur_y1   <= head.y1;
            if (head.is_fill) filler_color_q <= head.color[23:0];
            else              line_color_q   <= head.color;
         end
         case (state_n)
            S_L_X0:  line_point_q <= cur_x0;
            S_L_Y0:  line_point_q <= cur_y0;
            S_L_X1:  line_point_q <= cur_x1;
            S_L_Y1:  line_point_q <= cur_y1;
            default: ;
         endcase
         color_v <= (state_n == S_L_COLOR);
         x0_v    <= (state_n == S_L_X0);
         y0_v    <= (state_n == S_L_Y0);
         x1_v    <= (state_n == S_L_X1);
         y1_v    <= (state_n == S_L_Y1);
         trig_v  <= (state_n == S_L_TRIG);
         fill_v  <= (state_n == S_F_REQ);
      end
   end

   assign count_ext = 32'(count);
   assign occ       = (count_ext > 32'd7) ? 3'd7 : 3'(count_ext);
   assign status    = {25'd0, occ, overflow, bus.gfx_idle, empty, full};

   always_comb begin
      bus.mmio_dout = '0;
      case (bus.mmio_addr)
         3'd0:    bus.mmio_dout = color_r;
         3'd1:    bus.mmio_dout = 32'(x0_r);
         3'd2:    bus.mmio_dout = 32'(y0_r);
         3'd3:    bus.mmio_dout = 32'(x1_r);
         3'd4:    bus.mmio_dout = 32'(y1_r);
         3'd7:    bus.mmio_dout = status;
         default: bus.mmio_dout = '0;
      endcase
   end

   assign bus.gfx_idle         = empty && (state == S_IDLE);
   assign bus.line_color       = line_color_q;
   assign bus.line_point       = line_point_q;
   assign bus.line_color_valid = color_v;
   assign bus.line_x0_valid    = x0_v;
   assign bus.line_y0_valid    = y0_v;
   assign bus.line_x1_valid    = x1_v;
   assign bus.line_y1_valid    = y1_v;
   assign bus.line_trigger     = trig_v;
   assign bus.filler_color     = filler_color_q;
   assign bus.filler_valid     = fill_v;
endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// Directed and randomized checks of gfx_cmd_scheduler against a transfer-level
// model: every accepted GO expands into its expected engine handshakes in push order.
module tb_gfx_cmd_scheduler;
   localparam int unsigned PT_W = 10;

   logic clk;
   logic rst;
   gfx_cmd_if #(.PT_W(PT_W)) bus();

   gfx_cmd_scheduler #(.FIFO_DEPTH(4), .PT_W(PT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int onehot_err = 0;
   int obs_rd = 0;
   bit rnd = 1'b0;
   logic [35:0] obs [$];
   logic [35:0] exp_q [$];
   logic [31:0] sh_color = '0;
   logic [PT_W-1:0] sh_x0 = '0, sh_y0 = '0, sh_x1 = '0, sh_y1 = '0;

   function automatic logic [6:0] vec();
      return {bus.line_color_valid, bus.line_x0_valid, bus.line_y0_valid, bus.line_x1_valid,
              bus.line_y1_valid, bus.line_trigger, bus.filler_valid};
   endfunction

   // Records every completed handshake as {kind, data}, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         if ($countones(vec()) > 1) onehot_err++;
         if (bus.line_ready) begin
            if (bus.line_color_valid) obs.push_back({4'd0, bus.line_color});
            if (bus.line_x0_valid)    obs.push_back({4'd1, 32'(bus.line_point)});
            if (bus.line_y0_valid)    obs.push_back({4'd2, 32'(bus.line_point)});
            if (bus.line_x1_valid)    obs.push_back({4'd3, 32'(bus.line_point)});
            if (bus.line_y1_valid)    obs.push_back({4'd4, 32'(bus.line_point)});
            if (bus.line_trigger)     obs.push_back({4'd5, 32'd0});
         end
         if (bus.filler_ready && bus.filler_valid) obs.push_back({4'd6, 8'h00, bus.filler_color});
      end
   end

   task automatic chk(input string tag, input logic [35:0] observed, input logic [35:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd) begin
         bus.line_ready   = ($urandom_range(0, 3) != 0);
         bus.filler_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic push_line();
      exp_q.push_back({4'd0, sh_color});
      exp_q.push_back({4'd1, 32'(sh_x0)});
      exp_q.push_back({4'd2, 32'(sh_y0)});
      exp_q.push_back({4'd3, 32'(sh_x1)});
      exp_q.push_back({4'd4, 32'(sh_y1)});
      exp_q.push_back({4'd5, 32'd0});
   endtask

   task automatic mmio_write(input logic [2:0] a, input logic [31:0] d, input bit accept = 1'b1);
      bus.mmio_we   = 1'b1;
      bus.mmio_addr = a;
      bus.mmio_din  = d;
      case (a)
         3'd0: sh_color = d;
         3'd1: sh_x0 = d[PT_W-1:0];
         3'd2: sh_y0 = d[PT_W-1:0];
         3'd3: sh_x1 = d[PT_W-1:0];
         3'd4: sh_y1 = d[PT_W-1:0];
         3'd5: if (accept) push_line();
         3'd6: if (accept) exp_q.push_back({4'd6, 8'h00, d[23:0]});
         default: ;
      endcase
      tick();
      bus.mmio_we = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] expected);
      bus.mmio_addr = a;
      #1;
      chk(tag, 36'(bus.mmio_dout), 36'(expected));
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int k;
      k = 0;
      while (!bus.gfx_idle && k < bound) begin
         tick();
         k++;
      end
      chk({tag, "_idle"}, 36'(bus.gfx_idle), 36'(1));
   endtask

   task automatic sb_check(input string tag);
      int n;
      n = obs.size() - obs_rd;
      chk({tag, "_len"}, 36'(n), 36'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n; i++) chk(tag, obs[obs_rd + i], exp_q[i]);
      obs_rd = obs.size();
      exp_q.delete();
   endtask

   task automatic line_cmd();
      mmio_write(3'd0, 32'h00FF00FF);
      mmio_write(3'd1, 32'hABCD0003);
      mmio_write(3'd2, 32'd4);
      mmio_write(3'd3, 32'd100);
      mmio_write(3'd4, 32'd200);
   endtask

   initial begin
      rst = 1'b0;
      bus.mmio_we = 1'b0;
      bus.mmio_addr = 3'd0;
      bus.mmio_din = '0;
      bus.line_ready = 1'b0;
      bus.filler_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;

      // Reset state
      chk("rst_valids", 36'(vec()), 36'(0));
      chk("rst_idle", 36'(bus.gfx_idle), 36'(1));
      chk("rst_point", 36'(bus.line_point), 36'(0));
      chk_reg("rst_status", 3'd7, 32'h6);
      chk_reg("rst_color", 3'd0, 32'h0);

      // Single line, engine always ready
      bus.line_ready = 1'b1;
      bus.filler_ready = 1'b1;
      line_cmd();
      chk_reg("x0_masked", 3'd1, 32'd3);
      chk_reg("x1_read", 3'd3, 32'd100);
      mmio_write(3'd5, 32'hDEADBEEF);
      chk("t1_busy", 36'(bus.gfx_idle), 36'(0));
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t1_vec", 36'(vec()), 36'(7'b1000000 >> k));
         if (k == 0) chk("t1_color", 36'(bus.line_color), 36'h00FF00FF);
         if (k == 1) chk("t1_x0", 36'(bus.line_point), 36'd3);
         if (k == 4) chk("t1_y1", 36'(bus.line_point), 36'd200);
      end
      tick();
      chk("t1_drain", 36'({vec(), bus.gfx_idle}), 36'(0));
      tick();
      chk("t1_wait", 36'({vec(), bus.gfx_idle}), 36'(0));
      tick();
      chk("t1_idle", 36'(bus.gfx_idle), 36'(1));
      chk_reg("t1_status", 3'd7, 32'h6);
      sb_check("t1_sb");

      // line_ready stalls in L_X1
      mmio_write(3'd5, 32'd0);
      for (int k = 0; k < 4; k++) tick();
      chk("t2_x1", 36'(vec()), 36'(7'b0001000));
      bus.line_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t2_hold", 36'(vec()), 36'(7'b0001000));
         chk("t2_point", 36'(bus.line_point), 36'd100);
      end
      bus.line_ready = 1'b1;
      tick();
      chk("t2_y1", 36'(vec()), 36'(7'b0000100));
      chk("t2_y1pt", 36'(bus.line_point), 36'd200);
      wait_idle("t2", 50);
      sb_check("t2_sb");

      // Fill stalls, queued line must wait
      bus.filler_ready = 1'b0;
      mmio_write(3'd6, 32'hAA123456);
      mmio_write(3'd5, 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk("t3_fill", 36'(vec()), 36'(7'b0000001));
         chk("t3_fcolor", 36'(bus.filler_color), 36'h123456);
         tick();
      end
      bus.filler_ready = 1'b1;
      chk("t3_fill_last", 36'(vec()), 36'(7'b0000001));
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t3_gap", 36'(vec()), 36'(0));
      end
      tick();
      chk("t3_line", 36'(vec()), 36'(7'b1000000));
      chk("t3_lcolor", 36'(bus.line_color), 36'h00FF00FF);
      wait_idle("t3", 50);
      sb_check("t3_sb");

      // FIFO fill and overflow with both engines stalled
      bus.line_ready = 1'b0;
      bus.filler_ready = 1'b0;
      mmio_write(3'd5, 32'd0);
      mmio_write(3'd6, 32'h00ABCDEF);
      mmio_write(3'd0, 32'h11223344);
      mmio_write(3'd5, 32'd0);
      mmio_write(3'd6, 32'h00765432);
      mmio_write(3'd5, 32'd0);
      chk_reg("t4_full", 3'd7, 32'h41);
      chk("t4_head", 36'(vec()), 36'(7'b1000000));
      mmio_write(3'd6, 32'h00FFFFFF, 1'b0);
      chk_reg("t4_ovf", 3'd7, 32'h49);
      mmio_write(3'd7, 32'hFFFFFFF7);
      chk_reg("t4_ovf_keep", 3'd7, 32'h49);
      mmio_write(3'd7, 32'h8);
      chk_reg("t4_ovf_clr", 3'd7, 32'h41);
      bus.line_ready = 1'b1;
      bus.filler_ready = 1'b1;
      wait_idle("t4", 200);
      sb_check("t4_sb");

      // Reset in the middle of a line
      mmio_write(3'd5, 32'd0);
      tick();
      tick();
      tick();
      chk("t5_y0", 36'(vec()), 36'(7'b0010000));
      rst = 1'b0;
      tick();
      chk("t5_rst_vec", 36'(vec()), 36'(0));
      rst = 1'b1;
      chk_reg("t5_status", 3'd7, 32'h6);
      chk_reg("t5_color", 3'd0, 32'h0);
      sh_color = '0;
      sh_x0 = '0;
      sh_y0 = '0;
      sh_x1 = '0;
      sh_y1 = '0;
      obs_rd = obs.size();
      exp_q.delete();

      // Randomized bursts with random engine back-pressure
      rnd = 1'b1;
      for (int r = 0; r < 20; r++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++)
            mmio_write(3'($urandom_range(0, 4)), $urandom);
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
            if ($urandom_range(0, 1) == 1) mmio_write(3'($urandom_range(0, 4)), $urandom);
            mmio_write(($urandom_range(0, 1) == 1) ? 3'd5 : 3'd6, $urandom);
         end
         wait_idle("rnd", 1000);
         sb_check("rnd_sb");
      end
      rnd = 1'b0;

      chk("onehot", 36'(onehot_err), 36'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
